debug_tx_dumper: RTL and testbench
==================================

Name: debug_tx_dumper

Overview:
Transmit-side debug unit: after the pipeline halts or completes a step, it serializes the machine state into a byte stream for the UART TX FIFO. This is the mirror of the instruction loader, which consumes bytes through din/empty. Frame order is PC, cycle count, register file r0..r31, then data memory words 0..N_MEM_WORDS-1. Every 32-bit word is sent LSB first, the same byte order the loader receives instructions in.

Parameters:
NB_DATA, 32, word width.
NB_BYTE, 8, UART byte width.
N_REGS, 32, registers dumped.
NB_REG_ADDR, 5, register read address width.
N_MEM_WORDS, 32, data memory words dumped.
NB_MEM_ADDR, 7, data memory read address width (word index).

Ports:
clock  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high.
start  in  1  one-cycle request to dump state.
pc  in  NB_DATA  current program counter.
cycle_count  in  NB_DATA  pipeline cycle counter.
reg_rd_addr  out  NB_REG_ADDR  register file debug read address.
reg_rd_data  in  NB_DATA  register data, valid one cycle after address.
mem_rd_addr  out  NB_MEM_ADDR  data memory debug read address.
mem_rd_data  in  NB_DATA  memory data, valid one cycle after address.
tx_data  out  NB_BYTE  byte to UART TX.
tx_start  out  1  one-cycle pulse: tx_data valid, begin transmit.
tx_done_tick  in  1  UART finished current byte.
busy  out  1  dump in progress.
finish_send  out  1  one-cycle pulse after last byte is acknowledged.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset is synchronous and active-high. It dominates every state. Reset mid-dump returns to IDLE at the next edge with tx_start=0 and busy=0, and no finish_send is produced.
- Frame length is 4*(2+N_REGS+N_MEM_WORDS) bytes, 264 at defaults.
- FSM: IDLE, FETCH, LOAD, SEND, WAIT, DONE.
- IDLE:
  - start=1 snapshots pc and cycle_count, sets busy=1, section=PC, word_idx=0, and goes to FETCH.
  - All other inputs are ignored, including tx_done_tick.
- FETCH:
  - Drives reg_rd_addr=word_idx in the REG section, or mem_rd_addr=word_idx in the MEM section. Goes to LOAD.
- LOAD:
  - Loads the shift register from the source for the current section: PC snapshot, cycle snapshot, reg_rd_data or mem_rd_data.
  - Sets byte_cnt=0 and goes to SEND.
- SEND:
  - tx_start=1 for exactly one cycle, with tx_data=shift[7:0]. Goes to WAIT.
  - tx_data holds stable until the next SEND.
- WAIT:
  - Waits indefinitely for tx_done_tick.
  - On a tick with byte_cnt<3: shift right 8, byte_cnt+1, go to SEND.
  - On a tick with byte_cnt==3, the word advances:
    - PC goes to CYCLES.
    - CYCLES goes to REG, word_idx=0.
    - REG goes to REG, word_idx+1; after word_idx==N_REGS-1 it goes to MEM, word_idx=0.
    - MEM goes to MEM, word_idx+1; after word_idx==N_MEM_WORDS-1 it goes to DONE.
    - Otherwise the next state is FETCH.
- DONE: finish_send=1 for one cycle, busy=0 at the next edge, go to IDLE.
- Latency:
  - start accepted at edge N gives the first tx_start during cycle N+3 (FETCH, LOAD, SEND).
  - Between words, tx_done_tick to the next tx_start is 3 cycles; within a word it is 1 cycle.
- Simultaneous events:
  - start while busy is ignored.
  - tx_done_tick outside WAIT is ignored; this includes the SEND cycle itself.
  - start and reset together: reset wins.
- The snapshot is taken only at start. Later pc/cycle_count changes do not affect the frame.
- Counters are sized to hold max(N_REGS, N_MEM_WORDS)-1 and never wrap inside a frame.

Decomposition:
- Shared package debug_pkg holds:
  - state encoding localparams;
  - section codes PC, CYCLES, REG, MEM;
  - BYTES_PER_WORD=4;
  - FRAME_BYTES.
- The loader FSM and top_pipeline reuse these.
- One natural sub-module, word_byte_serializer. It takes load/word_in, runs the SEND/WAIT byte loop over 4 bytes, and returns word_done. The top FSM handles sectioning and addressing.

Test Plan:
1. Full dump:
   - Stimulus: reset, then start with pc=0x00000010, cycle_count=0x0000002A, r[i]=i, mem[i]=0xA5000000+i; tx_done_tick 4 cycles after each tx_start.
   - Expected: bytes 10 00 00 00 2A 00 00 00 00 00 00 00 01 00 00 00 …, last four bytes 1F 00 00 A5, 264 tx_start pulses, one finish_send.
2. Endianness and latency:
   - Stimulus: r3=0x80230000.
   - Expected: bytes 00 00 23 80 at offsets 20..23; first tx_start exactly 3 cycles after start; reg_rd_addr=3 during that word's FETCH.
3. Back-pressure:
   - Stimulus: hold tx_done_tick low for 100 cycles after byte 5.
   - Expected: no further tx_start, tx_data unchanged, busy=1; the stream resumes correctly on the tick.
4. Spurious inputs:
   - Stimulus: start pulses during the dump, tx_done_tick in IDLE and in the SEND cycle.
   - Expected: still exactly 264 bytes, single finish_send.
5. Reset mid-operation:
   - Stimulus: reset after byte 50.
   - Expected: tx_start=0, busy=0, no finish_send; a new start restarts at PC byte 0 with a fresh snapshot.
6. Snapshot:
   - Stimulus: change pc to 0xDEADBEEF one cycle after start.
   - Expected: the frame still begins 10 00 00 00.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared encodings for the debug dump/load path: FSM states, frame sections
// and frame geometry helpers.
package debug_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] SEC_PC     = 2'd0;
    localparam logic [1:0] SEC_CYCLES = 2'd1;
    localparam logic [1:0] SEC_REG    = 2'd2;
    localparam logic [1:0] SEC_MEM    = 2'd3;

    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic int unsigned frame_bytes(input int unsigned n_regs,
                                                input int unsigned n_mem);
        return BYTES_PER_WORD * (2 + n_regs + n_mem);
    endfunction

    // Word index width must cover the larger of the two dumped sections.
    function automatic int unsigned idx_width(input int unsigned n_regs,
                                              input int unsigned n_mem);
        int unsigned n_max;
        n_max = (n_regs > n_mem) ? n_regs : n_mem;
        return (n_max > 1) ? $clog2(n_max) : 1;
    endfunction

    localparam int unsigned FRAME_BYTES = frame_bytes(32, 32);

endpackage

// File: rtl/debug_tx_dumper_word_byte_serializer.sv
// Splits one loaded word into BYTES_PER_WORD bytes, LSB first, advancing on
// each acknowledged byte and flagging the acknowledgement of the last one.
module word_byte_serializer
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [NB_DATA-1:0] word_in,
    input  logic               send,
    input  logic               ack,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_start,
    output logic               word_done
);

    localparam int unsigned NB_CNT = $clog2(BYTES_PER_WORD);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BYTES_PER_WORD - 1);

    logic [NB_DATA-1:0] shift;
    logic [NB_CNT-1:0]  byte_cnt;

    // The last byte is not shifted out, so tx_data stays put until the next load.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            shift    <= word_in;
            byte_cnt <= '0;
        end else if (ack && (byte_cnt != LAST_BYTE)) begin
            shift    <= shift >> NB_BYTE;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    assign tx_data   = shift[NB_BYTE-1:0];
    assign tx_start  = send;
    assign word_done = ack && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/debug_tx_dumper.sv
// Serializes PC, cycle count, register file and data memory into a byte
// stream for the UART TX path after a halt or single step.
module debug_tx_dumper
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_BYTE     = 8,
    parameter int unsigned N_REGS      = 32,
    parameter int unsigned NB_REG_ADDR = 5,
    parameter int unsigned N_MEM_WORDS = 32,
    parameter int unsigned NB_MEM_ADDR = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NB_DATA-1:0]     pc,
    input  logic [NB_DATA-1:0]     cycle_count,
    output logic [NB_REG_ADDR-1:0] reg_rd_addr,
    input  logic [NB_DATA-1:0]     reg_rd_data,
    output logic [NB_MEM_ADDR-1:0] mem_rd_addr,
    input  logic [NB_DATA-1:0]     mem_rd_data,
    output logic [NB_BYTE-1:0]     tx_data,
    output logic                   tx_start,
    input  logic                   tx_done_tick,
    output logic                   busy,
    output logic                   finish_send
);

    localparam int unsigned NB_IDX = idx_width(N_REGS, N_MEM_WORDS);
    localparam logic [NB_IDX-1:0] LAST_REG = NB_IDX'(N_REGS - 1);
    localparam logic [NB_IDX-1:0] LAST_MEM = NB_IDX'(N_MEM_WORDS - 1);

    logic [2:0]         state;
    logic [1:0]         section;
    logic [NB_IDX-1:0]  word_idx;
    logic [NB_DATA-1:0] pc_snap;
    logic [NB_DATA-1:0] cycle_snap;
    logic [NB_DATA-1:0] word_in;
    logic               ack;
    logic               word_done;

    assign ack = (state == ST_WAIT) && tx_done_tick;

    always_comb begin
        word_in = '0;
        case (section)
            SEC_PC:     word_in = pc_snap;
            SEC_CYCLES: word_in = cycle_snap;
            SEC_REG:    word_in = reg_rd_data;
            default:    word_in = mem_rd_data;
        endcase
    end

    // Address is held for the whole word so the one-cycle read latency lines up with LOAD.
    assign reg_rd_addr = (section == SEC_REG) ? NB_REG_ADDR'(word_idx) : '0;
    assign mem_rd_addr = (section == SEC_MEM) ? NB_MEM_ADDR'(word_idx) : '0;
    assign finish_send = (state == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            section    <= SEC_PC;
            word_idx   <= '0;
            pc_snap    <= '0;
            cycle_snap <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc_snap    <= pc;
                        cycle_snap <= cycle_count;
                        busy       <= 1'b1;
                        section    <= SEC_PC;
                        word_idx   <= '0;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD:  state <= ST_SEND;
                ST_SEND:  state <= ST_WAIT;
                ST_WAIT: begin
                    if (ack && !word_done) begin
                        state <= ST_SEND;
                    end else if (word_done) begin
                        state <= ST_FETCH;
                        case (section)
                            SEC_PC: section <= SEC_CYCLES;
                            SEC_CYCLES: begin
                                section  <= SEC_REG;
                                word_idx <= '0;
                            end
                            SEC_REG: begin
                                if (word_idx == LAST_REG) begin
                                    section  <= SEC_MEM;
                                    word_idx <= '0;
                                end else begin
                                    word_idx <= word_idx + 1'b1;
                                end
                            end
                            default: begin
                                if (word_idx == LAST_MEM) begin
                                    state <= ST_DONE;
                                end else begin
                                    word_idx <= word_idx + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .clock     (clock),
        .reset     (reset),
        .load      (state == ST_LOAD),
        .word_in   (word_in),
        .send      (state == ST_SEND),
        .ack       (ack),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_debug_tx_dumper.sv
// Self-checking bench for debug_tx_dumper: scoreboarded byte stream, spot-check
// table, latency, back-pressure, spurious inputs, mid-dump reset and snapshot.
module tb_debug_tx_dumper;

    localparam int unsigned FRAME_LEN = 4 * (2 + 32 + 32);

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] cycle_count;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic [6:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done_tick;
    logic        busy;
    logic        finish_send;
    logic        uart_tick;
    logic        spur_tick;

    always #5 clock = ~clock;

    assign tx_done_tick = uart_tick | spur_tick;

    debug_tx_dumper #(
        .NB_DATA     (32),
        .NB_BYTE     (8),
        .N_REGS      (32),
        .NB_REG_ADDR (5),
        .N_MEM_WORDS (32),
        .NB_MEM_ADDR (7)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pc           (pc),
        .cycle_count  (cycle_count),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_data  (reg_rd_data),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .finish_send  (finish_send)
    );

    // Synchronous-read register file and data memory models
    logic [31:0] rf [32];
    logic [31:0] mem [128];
    logic [31:0] rf_q;
    logic [31:0] mem_q;

    always @(posedge clock) begin
        rf_q  <= rf[reg_rd_addr];
        mem_q <= mem[mem_rd_addr];
    end

    assign reg_rd_data = rf_q;
    assign mem_rd_data = mem_q;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    logic [7:0] byte_log[$];
    int frame_cnt = 0;
    int fs_cnt = 0;
    int stall_idx = -1;
    bit inject_send_tick = 1'b0;

    typedef struct {
        int unsigned offset;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [31:0] p, input logic [31:0] c);
        logic [31:0] w;
        for (int unsigned i = 0; i < 66; i++) begin
            if (i == 0)      w = p;
            else if (i == 1) w = c;
            else if (i < 34) w = rf[5'(i - 2)];
            else             w = mem[7'(i - 34)];
            for (int unsigned b = 0; b < 4; b++) sb.push_back(w[8*b +: 8]);
        end
    endfunction

    // Monitor: scoreboard compare of each byte, fetch-address history, finish count
    logic [4:0] ra_h1 = '0, ra_h2 = '0;
    logic [6:0] ma_h1 = '0, ma_h2 = '0;

    initial begin
        forever begin
            @(negedge clock);
            if (tx_start) begin
                if (frame_cnt == 20)  check("fetch_reg_addr_r3", 32'(ra_h2), 3);
                if (frame_cnt == 164) check("fetch_mem_addr_m7", 32'(ma_h2), 7);
                byte_log.push_back(tx_data);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=0x%0h required=no_byte", tx_data);
                end else begin
                    check($sformatf("byte[%0d]", frame_cnt), 32'(tx_data), 32'(sb.pop_front()));
                end
                frame_cnt++;
            end
            if (finish_send) fs_cnt++;
            ra_h2 = ra_h1;
            ra_h1 = reg_rd_addr;
            ma_h2 = ma_h1;
            ma_h1 = mem_rd_addr;
        end
    end

    // UART responder: tick ~4 cycles after each tx_start, optional stall and SEND-cycle tick
    initial begin
        logic [7:0] held;
        bit         bad;
        uart_tick = 1'b0;
        forever begin
            @(negedge clock);
            while (tx_start) begin
                if (inject_send_tick) uart_tick = 1'b1;
                @(negedge clock);
                uart_tick = 1'b0;
                if (stall_idx >= 0 && frame_cnt - 1 == stall_idx) begin
                    held = tx_data;
                    bad  = 1'b0;
                    repeat (100) begin
                        @(negedge clock);
                        if (tx_start || tx_data !== held || busy !== 1'b1) bad = 1'b1;
                    end
                    check("stall_hold", 32'(bad), 0);
                end
                repeat (2) @(negedge clock);
                uart_tick = 1'b1;
                @(negedge clock);
                uart_tick = 1'b0;
            end
        end
    end

    task automatic run_frame(input logic [31:0] p, input logic [31:0] c,
                             input bit perturb, input bit spur_start);
        int fs0;
        int lat;
        int guard;
        byte_log.delete();
        frame_cnt = 0;
        fs0 = fs_cnt;
        pc = p;
        cycle_count = c;
        push_frame(p, c);
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            start = 1'b0;
            if (perturb && lat == 1) begin
                pc = 32'hDEADBEEF;
                cycle_count = 32'hDEADBEEF;
            end
        end while (!tx_start && lat < 10);
        check("first_tx_start_latency", lat, 3);
        guard = 0;
        while (fs_cnt == fs0 && guard < 20000) begin
            @(negedge clock);
            guard++;
            start = (spur_start && (frame_cnt == 30 || frame_cnt == 100));
        end
        start = 1'b0;
        repeat (10) @(negedge clock);
        check("finish_pulses", fs_cnt - fs0, 1);
        check("frame_bytes", frame_cnt, FRAME_LEN);
        check("sb_drained", sb.size(), 0);
        check("busy_after_done", 32'(busy), 0);
        sb.delete();
    endtask

    initial begin
        int guard;
        int fs0;
        reset = 1'b1;
        start = 1'b0;
        pc = '0;
        cycle_count = '0;
        spur_tick = 1'b0;
        for (int i = 0; i < 32; i++) rf[5'(i)] = 32'(i);
        rf[3] = 32'h80230000;
        for (int i = 0; i < 128; i++) mem[7'(i)] = 32'hA5000000 + 32'(i);

        tbl[0]  = '{0,   8'h10}; tbl[1]  = '{1,   8'h00};
        tbl[2]  = '{2,   8'h00}; tbl[3]  = '{3,   8'h00};
        tbl[4]  = '{4,   8'h2A}; tbl[5]  = '{5,   8'h00};
        tbl[6]  = '{8,   8'h00}; tbl[7]  = '{12,  8'h01};
        tbl[8]  = '{20,  8'h00}; tbl[9]  = '{21,  8'h00};
        tbl[10] = '{22,  8'h23}; tbl[11] = '{23,  8'h80};
        tbl[12] = '{260, 8'h1F}; tbl[13] = '{261, 8'h00};
        tbl[14] = '{262, 8'h00}; tbl[15] = '{263, 8'hA5};

        repeat (3) @(negedge clock);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_finish_send", 32'(finish_send), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_reg_rd_addr", 32'(reg_rd_addr), 0);
        check("rst_mem_rd_addr", 32'(mem_rd_addr), 0);

        // start together with reset: reset wins
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("start_with_reset_busy", 32'(busy), 0);

        // Full dump with table spot checks
        run_frame(32'h00000010, 32'h0000002A, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            check($sformatf("tbl_offset_%0d", tbl[i].offset),
                  32'(byte_log[tbl[i].offset]), 32'(tbl[i].exp));

        // Tick while idle must not start anything
        spur_tick = 1'b1;
        @(negedge clock);
        spur_tick = 1'b0;
        @(negedge clock);
        check("idle_tick_ignored", 32'({busy, tx_start}), 0);

        // Snapshot perturbation, back-pressure, SEND-cycle ticks, spurious starts
        stall_idx = 5;
        inject_send_tick = 1'b1;
        run_frame(32'h00000010, 32'h0000002A, 1'b1, 1'b1);
        stall_idx = -1;
        inject_send_tick = 1'b0;
        check("snapshot_byte0", 32'(byte_log[0]), 32'h10);

        // Reset after byte 50
        byte_log.delete();
        frame_cnt = 0;
        pc = 32'h00000055;
        cycle_count = 32'h00000066;
        push_frame(pc, cycle_count);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (frame_cnt < 51 && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        check("reached_byte_50", 32'(frame_cnt >= 51), 1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_tx_start", 32'(tx_start), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_finish_send", 32'(finish_send), 0);
        reset = 1'b0;
        sb.delete();
        fs0 = fs_cnt;
        repeat (20) @(negedge clock);
        check("no_finish_after_reset", fs_cnt - fs0, 0);

        // Restart with a fresh snapshot
        run_frame(32'h00000077, 32'h00000099, 1'b0, 1'b0);
        check("restart_pc_byte0", 32'(byte_log[0]), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
